// File: rtl/fft_pkg.sv
// Shared defaults, FSM states and the bin-order helper
// for the FFT result readout path.
package fft_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_N         = 9;
  localparam int DEF_FFT_SIZE  = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // Reverse the low n bits of v; bits at and above n return 0.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          n
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rd_skid.sv
// Two-entry FIFO with a registered head; the head register
// drives the result bus directly.
module fft_rd_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] head_q;
  logic [W-1:0] spare_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      spare_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            head_q <= din;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= din;
          end else if (push) begin
            spare_q <= din;
            cnt_q   <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= spare_q;
            if (push) spare_q <= din;
            else      cnt_q   <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign dout  = head_q;
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/fft_readout.sv
// Streams one FFT frame out of result RAM in natural bin
// order through a credit-limited read pipe and skid FIFO.
module fft_readout
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N,
  parameter int FFT_SIZE  = DEF_FFT_SIZE,
  parameter int BITREV    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  output logic                   rd_en,
  output logic [N-1:0]           rd_addr,
  input  logic [2*BIT_WIDTH-1:0] rd_data,
  output logic [2*BIT_WIDTH-1:0] fft_result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_last,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [N:0] LAST = (N+1)'(FFT_SIZE - 1);
  localparam logic [N:0] ONE  = (N+1)'(1);

  state_t       state_q;
  state_t       state_d;
  logic [N:0]   issue_q;
  logic [N:0]   xfer_q;
  logic         inflight_q;
  logic         overrun_q;
  logic         start;
  logic         pop;
  logic [1:0]   fifo_cnt;
  logic [2:0]   credit;
  logic [N-1:0] addr_lin;
  logic [N-1:0] addr_rev;

  assign start = (state_q == ST_IDLE) && fft_done;
  assign pop   = result_valid && result_ready;

  // A read may go out when the slot freed by this cycle's
  // transfer keeps buffered plus in-flight data within two.
  assign credit = {1'b0, fifo_cnt} + {2'b0, inflight_q};
  assign rd_en  = (state_q == ST_STREAM) &&
                  (credit < (3'd2 + {2'b0, pop}));

  assign addr_lin = issue_q[N-1:0];
  assign addr_rev = N'(bitrev(32'(addr_lin), N));
  assign rd_addr  = (BITREV != 0) ? addr_rev : addr_lin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fft_done) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_en && issue_q == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && xfer_q == LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_q    <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      overrun_q  <= fft_done && (state_q != ST_IDLE);
      if (start) begin
        issue_q <= '0;
        xfer_q  <= '0;
      end else begin
        if (rd_en) issue_q <= issue_q + ONE;
        if (pop)   xfer_q  <= xfer_q + ONE;
      end
    end
  end

  fft_rd_skid #(
    .W(2*BIT_WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .din   (rd_data),
    .pop   (pop),
    .dout  (fft_result),
    .valid (result_valid),
    .count (fifo_cnt)
  );

  assign result_last = result_valid && (xfer_q == LAST);
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_readout.sv
// Randomised bench for fft_readout: bit-reversed and linear
// instances against a transaction-level frame model.
module tb_fft_readout;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fft_done;
  logic        ready;
  int          rdy_mode;

  logic        rd_en_b,  rd_en_l;
  logic [8:0]  rd_addr_b, rd_addr_l;
  logic [31:0] rd_data_b, rd_data_l;
  logic [31:0] res_b,    res_l;
  logic        val_b,    val_l;
  logic        last_b,   last_l;
  logic        busy_b,   busy_l;
  logic        ovr_b,    ovr_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_readout #(.BITREV(1)) u_br (
    .clk          (clk),
    .reset        (rst_n),
    .fft_done     (fft_done),
    .rd_en        (rd_en_b),
    .rd_addr      (rd_addr_b),
    .rd_data      (rd_data_b),
    .fft_result   (res_b),
    .result_valid (val_b),
    .result_ready (ready),
    .result_last  (last_b),
    .busy         (busy_b),
    .overrun      (ovr_b)
  );

  fft_readout #(.BITREV(0)) u_lin (
    .clk          (clk),
    .reset        (rst_n),
    .fft_done     (fft_done),
    .rd_en        (rd_en_l),
    .rd_addr      (rd_addr_l),
    .rd_data      (rd_data_l),
    .fft_result   (res_l),
    .result_valid (val_l),
    .result_ready (ready),
    .result_last  (last_l),
    .busy         (busy_l),
    .overrun      (ovr_l)
  );

  function automatic logic [31:0] word(input int a);
    logic [15:0] x;
    x = a[15:0];
    return {x, ~x};
  endfunction

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 9; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en_b) rd_data_b <= word(int'(rd_addr_b));
    if (rd_en_l) rd_data_l <= word(int'(rd_addr_l));
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: counts of reads issued, data landed and
  // bins transferred; everything follows from those.
  bit m_busy = 0;
  int m_issued = 0, m_xfers = 0, m_landed = 0;
  bit rd_d1 = 0, exp_ovr = 0;
  int cyc = 0, t_done = 0, t_last = 0;
  int dut_rd = 0, dut_xf = 0, ovr_seen = 0;

  always @(negedge clk) begin
    bit ev, xf, er;
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_xfers = 0; m_landed = 0;
      rd_d1 = 0; exp_ovr = 0;
    end else begin
      cyc++;
      ev = (m_landed > m_xfers);
      xf = ev && ready;
      er = m_busy && (m_issued < 512) &&
           ((m_issued - m_xfers - int'(xf)) < 2);
      check("busy_b", busy_b, m_busy);
      check("busy_l", busy_l, m_busy);
      check("ovr_b", ovr_b, exp_ovr);
      check("ovr_l", ovr_l, exp_ovr);
      check("rd_en_b", rd_en_b, er);
      check("rd_en_l", rd_en_l, er);
      if (er) begin
        check("addr_b", rd_addr_b, brev(m_issued));
        check("addr_l", rd_addr_l, m_issued);
      end
      check("valid_b", val_b, ev);
      check("valid_l", val_l, ev);
      check("last_b", last_b, ev && m_xfers == 511);
      check("last_l", last_l, ev && m_xfers == 511);
      if (ev) begin
        check("data_b", res_b, word(brev(m_xfers)));
        check("data_l", res_l, word(m_xfers));
      end
      if (rd_en_b) dut_rd++;
      if (val_b && ready) dut_xf++;
      if (ovr_b) ovr_seen++;
      exp_ovr = fft_done && m_busy;
      if (fft_done && !m_busy) begin
        m_busy = 1; m_issued = 0; m_xfers = 0; m_landed = 0;
        rd_d1 = 0; t_done = cyc; dut_rd = 0; dut_xf = 0;
      end else begin
        m_landed += int'(rd_d1);
        rd_d1 = er;
        if (er) m_issued++;
        if (xf) begin
          if (m_xfers == 511) begin
            m_busy = 0;
            t_last = cyc;
          end
          m_xfers++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  endtask

  task automatic pulse();
    fft_done = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (m_busy && i < budget) begin
      tick();
      i++;
    end
    if (m_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int i = 0;
    while (m_xfers < n && i < budget) begin
      tick();
      i++;
    end
    if (m_xfers < n) check("xfer_timeout", m_xfers, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_b"},
          {rd_en_b, rd_addr_b, res_b, val_b, last_b, busy_b, ovr_b},
          64'd0);
    check({tag, "_l"},
          {rd_en_l, rd_addr_l, res_l, val_l, last_l, busy_l, ovr_l},
          64'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; fft_done = 1'b0; ready = 1'b0; rdy_mode = 0;
    repeat (3) tick();
    check_zero("rst_state");
    rst_n = 1'b1;
    tick();

    // full-rate frame: order, latency and length
    rdy_mode = 0;
    pulse();
    wait_idle(2000);
    check("frame_len", t_last - t_done, 514);
    check("frame_bins", dut_xf, 512);

    // random backpressure
    rdy_mode = 1;
    pulse();
    wait_idle(5000);
    check("rand_bins", dut_xf, 512);

    // consumer stalled right from the start
    rdy_mode = 2;
    pulse();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = val_b;
    end
    check("stall_valid", seen, 1);
    repeat (20) tick();
    check("stall_reads", dut_rd, 2);
    check("stall_head", res_b, word(0));
    rdy_mode = 0;
    wait_idle(2000);
    check("stall_bins", dut_xf, 512);

    // fft_done mid-frame and on the final transfer
    rdy_mode = 0;
    ovr_seen = 0;
    pulse();
    wait_xfers(100, 1000);
    pulse();
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      seen = val_b && last_b;
    end
    check("last_seen", seen, 1);
    pulse();
    wait_idle(100);
    repeat (3) tick();
    check("ovr_count", ovr_seen, 2);
    check("ovr_bins", dut_xf, 512);
    check("ovr_idle", busy_b, 0);

    // reset in the middle of a frame
    rdy_mode = 1;
    pulse();
    wait_xfers(300, 3000);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rdy_mode = 0;
    pulse();
    wait_idle(2000);
    check("restart_bins", dut_xf, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
